ccc_apb_cfg_master: RTL and testbench
=====================================

Name: ccc_apb_cfg_master

Overview:
APB initiator that drives the fabric CCC dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA). The CCC end is a fixed-timing responder with no PREADY.
- Accepts single-byte read/write commands from fabric control logic.
- Honours CCC BUSY before starting a command.
- After a committing write, supervises PLL re-lock with a hold-off and a timeout.
- Sits beside the CCC instance in the clocking subsystem and is clocked by PCLK.

Parameters:
LOCK_HOLDOFF, 64, cycles after a commit write during which LOCK is ignored (PLL loss propagation); must be >= 1.
LOCK_TIMEOUT, 4096, max cycles after hold-off to wait for lock before flagging error; must be >= 1.
SYNC_STAGES, 2, flops in the LOCK/BUSY synchronisers; must be >= 2.

Ports:
PCLK  in  1  APB/config clock.
PRESET_N  in  1  async active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when valid&ready.
cmd_write  in  1  1=write, 0=read.
cmd_commit  in  1  write only: wait for PLL re-lock before responding.
cmd_addr  in  6  CCC config register address.
cmd_wdata  in  8  write data.
rsp_valid  out  1  one-cycle response strobe, no backpressure.
rsp_rdata  out  8  read data (0 for writes).
rsp_err  out  1  valid with rsp_valid: lock timeout (or readback mismatch).
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  6  APB address.
PWDATA  out  8  APB write data.
PRDATA  in  8  APB read data from CCC.
CCC_BUSY  in  1  CCC busy, async to PCLK.
CCC_LOCK  in  1  PLL lock, async to PCLK.
lock_sync  out  1  synchronised LOCK.

Behaviour:
Clocking and reset:
- One clock, PCLK. PRESET_N is asynchronous and active-low.
- Reset (async assert): state=IDLE; all outputs 0 (cmd_ready, rsp_*, PSEL, PENABLE, PWRITE, PADDR, PWDATA, lock_sync); counters and synchronisers 0.
- Reset mid-transfer drops PSEL/PENABLE immediately. The aborted command gives no response.

Synchronisers and outputs:
- CCC_LOCK and CCC_BUSY pass through SYNC_STAGES-flop synchronisers. busy_s is internal; lock_sync is the LOCK synchroniser output.
- All APB outputs are registered. Outside SETUP/ACCESS: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.

States:
- IDLE: cmd_ready = !busy_s (registered). On cmd_valid&cmd_ready, latch write/commit/addr/wdata, go to SETUP. cmd_commit is ignored on reads.
- SETUP (1 cycle): PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA from the latch. Next state is ACCESS.
- ACCESS (1 cycle): PSEL=1, PENABLE=1. No wait states. Reads sample PRDATA on the clock edge ending ACCESS. Next state:
  - HOLDOFF if write&commit;
  - otherwise RESP.
- HOLDOFF: count LOCK_HOLDOFF cycles and ignore lock_sync, then clear the counter and go to LOCKWAIT.
- LOCKWAIT:
  - lock_sync=1 -> RESP, err=0.
  - Counter reaches LOCK_TIMEOUT-1 with lock_sync=0 -> RESP, err=1.
  - The counter never wraps.
- RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err, then IDLE. rsp_rdata/rsp_err hold their value until the next RESP.

Command acceptance and latency:
- cmd_ready=0 in every state except IDLE, and also in IDLE while busy_s=1.
- A command presented while BUSY is high waits. There is no timeout on BUSY.
- Read/no-commit latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
- Back-to-back: the next accept is possible at earliest N+4.

Optional Feature:
Macro: CCC_CFG_READBACK_EN.
- Defined: every write is followed by a readback before HOLDOFF/RESP.
  - Adds states RB_SETUP and RB_ACCESS: PSEL, same PADDR, PWRITE=0, PWDATA=0.
  - rsp_rdata = readback byte.
  - rsp_err is set if readback != written data, ORed with the timeout error.
  - Write latency without commit is N+5.
- Undefined: those states do not exist; write rsp_rdata=0; rsp_err reflects the timeout only.

Test Plan:
1. Reset, then read addr 0x05 with PRDATA model=0xA3 -> PSEL high at N+1 (PENABLE=0), PENABLE at N+2, rsp_valid at N+3, rsp_rdata=0xA3, rsp_err=0; APB outputs return to 0.
2. Write addr 0x10 data 0x5C, commit=0 -> PWRITE=1, PADDR=0x10, PWDATA=0x5C in SETUP/ACCESS; rsp_valid at N+3 (N+5 with CCC_CFG_READBACK_EN, rsp_rdata=0x5C).
3. CCC_BUSY=1 with cmd_valid held -> cmd_ready=0, no PSEL. Drop BUSY -> accept 1 cycle after busy_s falls.
4. Commit write with LOCK_HOLDOFF=4, LOCK_TIMEOUT=16; CCC_LOCK stays 1 throughout -> rsp at N+3+4+SYNC-independent 1 cycle, err=0. With CCC_LOCK low and never returning -> rsp_valid exactly at ACCESS+4+16(+1), rsp_err=1.
5. Assert PRESET_N=0 during ACCESS -> PSEL/PENABLE fall asynchronously, no rsp_valid. After release, a new read completes normally.
6. CCC_CFG_READBACK_EN: model corrupts readback (0x5C written, 0x5D read) -> rsp_err=1, rsp_rdata=0x5D.

Source files
------------

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the CCC dynamic-configuration port: single-byte commands, BUSY gating, PLL re-lock supervision.
// Optional write readback is enabled by defining CCC_CFG_READBACK_EN.
module ccc_apb_cfg_master #(
    parameter int LOCK_HOLDOFF = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       PCLK,
    input  logic       PRESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_commit,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [5:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       CCC_BUSY,
    input  logic       CCC_LOCK,
    output logic       lock_sync
);

    localparam int CNT_MAX = (LOCK_HOLDOFF > LOCK_TIMEOUT) ? LOCK_HOLDOFF : LOCK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(LOCK_HOLDOFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLDOFF,
        ST_LOCKWAIT,
        ST_RESP
`ifdef CCC_CFG_READBACK_EN
        ,
        ST_RB_SETUP,
        ST_RB_ACCESS
`endif
    } state_e;

    state_e                 state;
    logic [SYNC_STAGES-1:0] lock_ff;
    logic [SYNC_STAGES-1:0] busy_ff;
    logic                   busy_s;
    logic                   wr_q;
    logic                   commit_q;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             rdata_q;
    logic                   rb_err_q;
`ifdef CCC_CFG_READBACK_EN
    logic [7:0]             wdata_q;
`endif

    assign busy_s    = busy_ff[SYNC_STAGES-1];
    assign lock_sync = lock_ff[SYNC_STAGES-1];

    // NOTE: async active-low reset in the sensitivity list; every flop here, including the synchronisers, clears on it.
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            lock_ff <= '0;
            busy_ff <= '0;
        end else begin
            // NOTE: non-blocking shifts so each stage takes the previous stage's old value.
            lock_ff <= {lock_ff[SYNC_STAGES-2:0], CCC_LOCK};
            busy_ff <= {busy_ff[SYNC_STAGES-2:0], CCC_BUSY};
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            wr_q      <= 1'b0;
            commit_q  <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
            rb_err_q  <= 1'b0;
`ifdef CCC_CFG_READBACK_EN
            wdata_q   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wr_q      <= cmd_write;
                        commit_q  <= cmd_write & cmd_commit;
                        rdata_q   <= '0;
                        rb_err_q  <= 1'b0;
`ifdef CCC_CFG_READBACK_EN
                        wdata_q   <= cmd_wdata;
`endif
                        PSEL      <= 1'b1;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end else begin
                        cmd_ready <= !busy_s;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    PWDATA  <= '0;
`ifdef CCC_CFG_READBACK_EN
                    if (wr_q) begin
                        // Keep PSEL/PADDR up: the readback reuses the same register address.
                        state <= ST_RB_SETUP;
                    end else
`endif
                    begin
                        PSEL  <= 1'b0;
                        PADDR <= '0;
                        if (commit_q) begin
                            cnt   <= '0;
                            state <= ST_HOLDOFF;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= wr_q ? 8'h00 : PRDATA;
                            rsp_err   <= 1'b0;
                            state     <= ST_RESP;
                        end
                    end
                end

`ifdef CCC_CFG_READBACK_EN
                ST_RB_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_RB_ACCESS;
                end

                ST_RB_ACCESS: begin
                    PSEL     <= 1'b0;
                    PENABLE  <= 1'b0;
                    PADDR    <= '0;
                    rdata_q  <= PRDATA;
                    rb_err_q <= (PRDATA != wdata_q);
                    if (commit_q) begin
                        cnt   <= '0;
                        state <= ST_HOLDOFF;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PRDATA;
                        rsp_err   <= (PRDATA != wdata_q);
                        state     <= ST_RESP;
                    end
                end
`endif

                ST_HOLDOFF: begin
                    // Lock is ignored here: the PLL may not have dropped LOCK yet after the commit.
                    if (cnt == HOLDOFF_LAST) begin
                        cnt   <= '0;
                        state <= ST_LOCKWAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_LOCKWAIT: begin
                    if (lock_sync) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_q;
                        rsp_err   <= rb_err_q;
                        state     <= ST_RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_q;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    // Pre-load cmd_ready so a new command can be accepted in the first IDLE cycle.
                    cmd_ready <= !busy_s;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Self-checking bench for ccc_apb_cfg_master: directed cases plus random commands against a cycle-count reference model.
module tb_ccc_apb_cfg_master;

    localparam int H = 4;
    localparam int T = 16;
    localparam int S = 2;
    localparam int LK_HIGH = 0;
    localparam int LK_LOW  = 1;
    localparam int LK_RISE = 2;

    logic       PCLK = 1'b0;
    logic       PRESET_N = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic       cmd_commit = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL, PENABLE, PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       CCC_BUSY = 1'b0;
    logic       CCC_LOCK = 1'b0;
    logic       lock_sync;

    // Behavioural CCC register file; preload port used only while the DUT is in reset.
    logic [7:0] mem [64];
    logic [7:0] exp_mem [64];
    logic [7:0] corrupt = 8'h00;
    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (PSEL && PENABLE && PWRITE) mem[PADDR] <= PWDATA;
    end

    always_comb PRDATA = mem[PADDR] ^ corrupt;

    ccc_apb_cfg_master #(
        .LOCK_HOLDOFF(H),
        .LOCK_TIMEOUT(T),
        .SYNC_STAGES (S)
    ) dut (
        .PCLK      (PCLK),
        .PRESET_N  (PRESET_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_commit(cmd_commit),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .CCC_BUSY  (CCC_BUSY),
        .CCC_LOCK  (CCC_LOCK),
        .lock_sync (lock_sync)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, req, $time);
        end
    endtask

    // Issue one command at the current negedge and check every cycle up to one past the response.
    // Cycle k counts from the accepting edge: SETUP is k=1, ACCESS k=2.
    task automatic run_cmd(input logic wr, input logic cm, input logic [5:0] a,
                           input logic [7:0] d, input int mode);
        int         last_apb, rsp_k, w, seen, rise_k, waited;
        logic [7:0] e_rdata;
        logic       e_err, commit, rb, e_psel, e_pen;
        commit = wr && cm;
        rb     = 1'b0;
`ifdef CCC_CFG_READBACK_EN
        rb     = wr;
`endif
        last_apb = rb ? 4 : 2;
        e_err    = 1'b0;
        e_rdata  = wr ? 8'h00 : exp_mem[a];
        if (rb) begin
            e_rdata = d ^ corrupt;
            e_err   = (corrupt != 8'h00);
        end
        rise_k = -1;
        rsp_k  = last_apb + 1;
        if (commit) begin
            CCC_LOCK = (mode == LK_HIGH);
            repeat (S + 1) @(negedge PCLK);
            w = last_apb + H + 1;  // first cycle in which lock is looked at
            if (mode == LK_HIGH) begin
                rsp_k = w + 1;
            end else begin
                seen = 1 << 30;
                if (mode == LK_RISE) begin
                    rise_k = last_apb + 1 + $urandom_range(0, H + T);
                    seen   = rise_k + S;
                end
                if (seen <= w)              rsp_k = w + 1;
                else if (seen <= w + T - 1) rsp_k = seen + 1;
                else begin
                    rsp_k = w + T;
                    e_err = 1'b1;
                end
            end
        end
        if (wr) exp_mem[a] = d;

        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_commit = cm;
        cmd_addr   = a;
        cmd_wdata  = d;
        waited     = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge PCLK);
            waited++;
        end
        check("accept_in_budget", 32'(waited < 200), 32'd1);
        if (waited >= 200) begin
            cmd_valid = 1'b0;
            return;
        end

        for (int k = 1; k <= rsp_k + 1; k++) begin
            @(negedge PCLK);
            if (k == 1) cmd_valid = 1'b0;
            e_psel = (k == 1) || (k == 2) || (rb && (k == 3 || k == 4));
            e_pen  = (k == 2) || (rb && k == 4);
            check("psel", PSEL, e_psel);
            check("penable", PENABLE, e_pen);
            check("pwrite", PWRITE, wr && k <= 2);
            check("paddr", PADDR, e_psel ? a : 6'd0);
            if (wr && k <= 2)  check("pwdata_wr", PWDATA, d);
            else if (k > 2)    check("pwdata_idle", PWDATA, 8'd0);
            check("rsp_valid", rsp_valid, k == rsp_k);
            check("cmd_ready", cmd_ready, k == rsp_k + 1);
            if (k >= rsp_k) begin
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_err", rsp_err, e_err);
            end
            if (k == rise_k) CCC_LOCK = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and preload the register model.
        for (int i = 0; i < 64; i++) begin
            @(negedge PCLK);
            pre_we   = 1'b1;
            pre_addr = 6'(i);
            pre_data = (i == 5) ? 8'hA3 : 8'($urandom);
            exp_mem[i] = pre_data;
        end
        @(negedge PCLK);
        pre_we = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        check("rst_rsp_data", {rsp_rdata, rsp_err}, 0);
        check("rst_lock_sync", lock_sync, 1'b0);
        PRESET_N = 1'b1;
        @(negedge PCLK);
        check("ready_after_reset", cmd_ready, 1'b1);

        // Basic read and non-commit write.
        run_cmd(1'b0, 1'b0, 6'h05, 8'h00, LK_HIGH);
        run_cmd(1'b1, 1'b0, 6'h10, 8'h5C, LK_HIGH);
        run_cmd(1'b0, 1'b0, 6'h10, 8'h00, LK_HIGH);

        // BUSY holds off acceptance; ready returns one cycle after busy_s clears.
        CCC_BUSY = 1'b1;
        repeat (S + 2) @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'h05;
        repeat (4) begin
            @(negedge PCLK);
            check("busy_ready", cmd_ready, 1'b0);
            check("busy_psel", PSEL, 1'b0);
        end
        CCC_BUSY = 1'b0;
        @(negedge PCLK);
        check("busy_drop_1", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("busy_drop_2", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("busy_drop_3", cmd_ready, 1'b1);
        run_cmd(1'b0, 1'b0, 6'h05, 8'h00, LK_HIGH);

        // Commit writes: lock stays up, lock never returns, lock returns mid-wait.
        run_cmd(1'b1, 1'b1, 6'h21, 8'h3C, LK_HIGH);
        run_cmd(1'b1, 1'b1, 6'h22, 8'hC3, LK_LOW);
        run_cmd(1'b1, 1'b1, 6'h23, 8'h77, LK_RISE);
        run_cmd(1'b0, 1'b1, 6'h23, 8'h00, LK_LOW);

        // Reset during ACCESS: APB drops at once and no response follows.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'h05;
        while (!cmd_ready) @(negedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("pre_abort_penable", PENABLE, 1'b1);
        #1 PRESET_N = 1'b0;
        #1;
        check("abort_psel", PSEL, 1'b0);
        check("abort_penable", PENABLE, 1'b0);
        repeat (3) begin
            @(negedge PCLK);
            check("abort_no_rsp", rsp_valid, 1'b0);
        end
        PRESET_N = 1'b1;
        @(negedge PCLK);
        check("abort_ready", cmd_ready, 1'b1);
        run_cmd(1'b0, 1'b0, 6'h05, 8'h00, LK_HIGH);

`ifdef CCC_CFG_READBACK_EN
        // Readback returns a corrupted byte.
        corrupt = 8'h01;
        run_cmd(1'b1, 1'b0, 6'h10, 8'h5C, LK_HIGH);
        run_cmd(1'b1, 1'b1, 6'h11, 8'h5C, LK_HIGH);
        corrupt = 8'h00;
`endif

        // Random commands.
        for (int i = 0; i < 40; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    6'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
